// File: rtl/osc_tick_gen.sv
// Oscillator-domain startup holdoff followed by a programmable-period tick and
// 2-bit phase count, used as the 4-phase SCL timebase by the I2C bit engine.
module osc_tick_gen #(
   parameter int STARTUP_CYCLES = 1024,
   parameter int DIV_W          = 16,
   parameter int DEFAULT_DIV    = 63
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic [DIV_W-1:0] div_value,
   input  logic             div_load,
   output logic             ready,
   output logic             rst_out,
   output logic             tick,
   output logic [1:0]       tick_phase
);

   localparam int CNT_W = (STARTUP_CYCLES > 2) ? $clog2(STARTUP_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARTUP_CYCLES - 1);
   localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEFAULT_DIV);

   typedef enum logic [1:0] {
      ST_STARTUP,
      ST_IDLE,
      ST_RUN
   } state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [DIV_W-1:0] presc_reg, presc_next;
   logic [DIV_W-1:0] div_reg, div_next;
   logic [DIV_W-1:0] pend_reg, pend_next;
   logic             pend_valid_reg, pend_valid_next;
   logic             tick_reg, tick_next;
   logic [1:0]       phase_reg, phase_next;
   logic             ready_reg, ready_next;
   logic             run_meta_reg, run_s_reg;

   logic [DIV_W-1:0] div_eff;
   logic             step;
   logic             wrap;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= ST_STARTUP;
         cnt_reg        <= '0;
         presc_reg      <= '0;
         div_reg        <= DIV_RST;
         pend_reg       <= '0;
         pend_valid_reg <= 1'b0;
         tick_reg       <= 1'b0;
         phase_reg      <= 2'd0;
         ready_reg      <= 1'b0;
         run_meta_reg   <= 1'b0;
         run_s_reg      <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         presc_reg      <= presc_next;
         div_reg        <= div_next;
         pend_reg       <= pend_next;
         pend_valid_reg <= pend_valid_next;
         tick_reg       <= tick_next;
         phase_reg      <= phase_next;
         ready_reg      <= ready_next;
         run_meta_reg   <= run;
         run_s_reg      <= run_meta_reg;
      end
   end

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      presc_next      = presc_reg;
      div_next        = div_reg;
      pend_next       = pend_reg;
      pend_valid_next = pend_valid_reg;
      tick_next       = 1'b0;
      phase_next      = phase_reg;
      ready_next      = ready_reg;

      // Outside RUN a pending divider lands on this edge, so the period that
      // starts on the IDLE->RUN edge must already be measured against it.
      div_eff = (state_reg != ST_RUN && pend_valid_reg) ? pend_reg : div_reg;
      step    = run_s_reg && (state_reg != ST_STARTUP);
      wrap    = step && (presc_reg == div_eff);

      case (state_reg)
         ST_STARTUP: begin
            cnt_next   = cnt_reg + 1'b1;
            presc_next = '0;
            if (cnt_reg == CNT_LAST) begin
               state_next = ST_IDLE;
               ready_next = 1'b1;
            end
         end
         ST_IDLE: begin
            presc_next = '0;
            if (run_s_reg) state_next = ST_RUN;
         end
         ST_RUN: begin
            if (!run_s_reg) begin
               state_next = ST_IDLE;
               presc_next = '0;
            end
         end
         default: state_next = ST_STARTUP;
      endcase

      // The IDLE->RUN edge counts as the first cycle of the first period.
      if (step) begin
         presc_next = wrap ? '0 : presc_reg + 1'b1;
         tick_next  = wrap;
         if (wrap) phase_next = phase_reg + 2'd1;
      end

      if (state_reg == ST_RUN && wrap && div_load) begin
         div_next        = div_value;
         pend_valid_next = 1'b0;
      end else begin
         if (pend_valid_reg && (state_reg != ST_RUN || wrap)) begin
            div_next        = pend_reg;
            pend_valid_next = 1'b0;
         end
         if (div_load) begin
            pend_next       = div_value;
            pend_valid_next = 1'b1;
         end
      end
   end

   assign ready      = ready_reg;
   assign rst_out    = ~ready_reg;
   assign tick       = tick_reg;
   assign tick_phase = phase_reg;

endmodule

// File: tb/tb_osc_tick_gen.sv
// Self-checking bench for osc_tick_gen: directed scenarios plus a randomized run,
// all compared against an edge-indexed scheduling model of the tick timebase.
module tb_osc_tick_gen;

   localparam int SC   = 16;
   localparam int DW   = 16;
   localparam int DDIV = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          run = 1'b0;
   logic          div_load = 1'b0;
   logic [DW-1:0] div_value = '0;
   logic          ready;
   logic          rst_out;
   logic          tick;
   logic [1:0]    tick_phase;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   osc_tick_gen #(
      .STARTUP_CYCLES(SC),
      .DIV_W(DW),
      .DEFAULT_DIV(DDIV)
   ) dut (
      .clk(clk),
      .reset(reset),
      .run(run),
      .div_value(div_value),
      .div_load(div_load),
      .ready(ready),
      .rst_out(rst_out),
      .tick(tick),
      .tick_phase(tick_phase)
   );

   // Reference model: edges are numbered from reset release; a tick is
   // scheduled at an absolute edge index and rescheduled div+1 edges later.
   int m_edge, m_div, m_pend, m_next_tick, m_phase;
   bit m_pend_v, m_running, m_tick, m_ready;
   bit run_hist[$];

   task automatic model_reset();
      m_edge = 0; m_div = DDIV; m_pend = 0; m_pend_v = 0;
      m_running = 0; m_tick = 0; m_ready = 0; m_next_tick = 0; m_phase = 0;
      run_hist.delete();
   endtask

   task automatic model_edge();
      bit rs, was_run, due, ld_used;
      int n;
      run_hist.push_back(run);
      n = run_hist.size();
      rs = (n >= 3) ? run_hist[n-3] : 1'b0;
      m_edge++;
      was_run = m_running;
      ld_used = 0;
      m_tick = 0;
      if (m_edge >= SC) m_ready = 1;
      if (!was_run && m_pend_v) begin
         m_div = m_pend; m_pend_v = 0;
      end
      if (!was_run && rs && m_edge > SC) begin
         m_running = 1;
         m_next_tick = m_edge + m_div;
      end else if (was_run && !rs) begin
         m_running = 0;
      end
      due = m_running && (m_edge == m_next_tick);
      if (was_run && due) begin
         if (div_load) begin
            m_div = int'(div_value); m_pend_v = 0; ld_used = 1;
         end else if (m_pend_v) begin
            m_div = m_pend; m_pend_v = 0;
         end
      end
      if (div_load && !ld_used) begin
         m_pend = int'(div_value); m_pend_v = 1;
      end
      if (due) begin
         m_tick = 1;
         m_phase = (m_phase + 1) % 4;
         m_next_tick = m_edge + 1 + m_div;
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      #2;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(negedge clk);
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready); end
      checks++; if (rst_out !== 1'b1) begin errors++; $display("FAIL reset_rst_out got=%b exp=1", rst_out); end
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", tick); end
      checks++; if (tick_phase !== 2'd0) begin errors++; $display("FAIL reset_phase got=%0d exp=0", tick_phase); end
      #2;
      reset = 1'b0;
      model_reset();
      $display("test_reset: outputs at reset values");
   endtask

   task automatic test_startup();
      int rise = -1;
      run = 1'b0;
      for (int i = 1; i <= SC; i++) begin
         cyc();
         if (ready === 1'b1 && rise < 0) rise = i;
         checks++; if (ready !== m_ready) begin errors++; $display("FAIL startup_ready edge=%0d got=%b exp=%b", i, ready, m_ready); end
         checks++; if (rst_out !== !m_ready) begin errors++; $display("FAIL startup_rst_out edge=%0d got=%b exp=%b", i, rst_out, !m_ready); end
         checks++; if (tick !== 1'b0) begin errors++; $display("FAIL startup_tick edge=%0d got=%b exp=0", i, tick); end
      end
      checks++; if (rise != SC) begin errors++; $display("FAIL startup_rise_edge got=%0d exp=%0d", rise, SC); end
      $display("test_startup: ready rose after edge %0d", rise);
   endtask

   task automatic test_basic();
      int first = -1;
      int nt = 0;
      int ph[5];
      int exp_ph[5] = '{1, 2, 3, 0, 1};
      run = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         cyc();
         checks++; if (tick !== m_tick) begin errors++; $display("FAIL basic_tick edge=%0d got=%b exp=%b", i, tick, m_tick); end
         checks++; if (tick_phase !== 2'(m_phase)) begin errors++; $display("FAIL basic_phase edge=%0d got=%0d exp=%0d", i, tick_phase, m_phase); end
         if (tick === 1'b1) begin
            if (first < 0) first = i;
            if (nt < 5) ph[nt] = int'(tick_phase);
            nt++;
         end
      end
      checks++; if (first != 3 + DDIV) begin errors++; $display("FAIL basic_first_tick got=%0d exp=%0d", first, 3 + DDIV); end
      checks++; if (nt != 7) begin errors++; $display("FAIL basic_tick_count got=%0d exp=7", nt); end
      for (int k = 0; k < 5; k++) begin
         checks++; if (ph[k] != exp_ph[k]) begin errors++; $display("FAIL basic_phase_seq idx=%0d got=%0d exp=%0d", k, ph[k], exp_ph[k]); end
      end
      $display("test_basic: first tick after edge %0d, %0d ticks", first, nt);
   endtask

   task automatic wait_tick(input string tag, input int limit);
      int n = 0;
      do begin
         cyc();
         n++;
         checks++; if (tick !== m_tick) begin errors++; $display("FAIL %s_wait_tick got=%b exp=%b", tag, tick, m_tick); end
      end while (tick !== 1'b1 && n < limit);
      if (tick !== 1'b1) begin
         errors++; checks++;
         $display("FAIL %s_timeout got=no_tick exp=tick_within_%0d", tag, limit);
      end
   endtask

   task automatic measure_gap(input string tag, input int already, input int expected);
      int n = already;
      do begin
         cyc();
         n++;
         checks++; if (tick !== m_tick) begin errors++; $display("FAIL %s_tick got=%b exp=%b", tag, tick, m_tick); end
      end while (tick !== 1'b1 && n < 40);
      checks++; if (n != expected) begin errors++; $display("FAIL %s_interval got=%0d exp=%0d", tag, n, expected); end
   endtask

   task automatic test_div_change();
      wait_tick("divchg", 20);
      for (int i = 0; i < 3; i++) cyc();
      div_value = 16'd7; div_load = 1'b1;
      cyc();
      div_load = 1'b0;
      checks++; if (tick !== 1'b1) begin errors++; $display("FAIL divchg_wrap_tick got=%b exp=1", tick); end
      measure_gap("divchg_8", 0, 8);
      for (int i = 0; i < 3; i++) cyc();
      div_value = 16'd1; div_load = 1'b1;
      cyc();
      div_load = 1'b0;
      measure_gap("divchg_mid", 4, 8);
      measure_gap("divchg_2a", 0, 2);
      measure_gap("divchg_2b", 0, 2);
      $display("test_div_change: intervals 8 then 8 then 2");
   endtask

   task automatic test_stop_restart();
      int held;
      int n = 0;
      div_value = 16'd3; div_load = 1'b1;
      cyc();
      div_load = 1'b0;
      wait_tick("stop", 20);
      held = int'(tick_phase);
      cyc();
      run = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         checks++; if (tick !== 1'b0) begin errors++; $display("FAIL stop_tick_quiet cyc=%0d got=%b exp=0", i, tick); end
         checks++; if (tick_phase !== 2'(held)) begin errors++; $display("FAIL stop_phase_held cyc=%0d got=%0d exp=%0d", i, tick_phase, held); end
      end
      run = 1'b1;
      do begin
         cyc();
         n++;
         checks++; if (tick !== m_tick) begin errors++; $display("FAIL restart_tick got=%b exp=%b", tick, m_tick); end
      end while (tick !== 1'b1 && n < 20);
      checks++; if (n != 3 + 3) begin errors++; $display("FAIL restart_latency got=%0d exp=6", n); end
      checks++; if (tick_phase !== 2'((held + 1) % 4)) begin errors++; $display("FAIL restart_phase got=%0d exp=%0d", tick_phase, (held + 1) % 4); end
      $display("test_stop_restart: restart latency %0d, phase held at %0d", n, held);
   endtask

   task automatic test_async_reset();
      int t0 = -1;
      int t1 = -1;
      div_value = 16'd5; div_load = 1'b1;
      cyc();
      div_load = 1'b0;
      wait_tick("areset", 30);
      #3;
      reset = 1'b1;
      #1;
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL areset_tick got=%b exp=0", tick); end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL areset_ready got=%b exp=0", ready); end
      checks++; if (rst_out !== 1'b1) begin errors++; $display("FAIL areset_rst_out got=%b exp=1", rst_out); end
      checks++; if (tick_phase !== 2'd0) begin errors++; $display("FAIL areset_phase got=%0d exp=0", tick_phase); end
      @(negedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      for (int i = 1; i <= SC + 20; i++) begin
         cyc();
         checks++; if (ready !== m_ready) begin errors++; $display("FAIL areset_restart_ready edge=%0d got=%b exp=%b", i, ready, m_ready); end
         checks++; if (tick !== m_tick) begin errors++; $display("FAIL areset_restart_tick edge=%0d got=%b exp=%b", i, tick, m_tick); end
         if (tick === 1'b1) begin
            if (t0 < 0) t0 = i;
            else if (t1 < 0) t1 = i;
         end
      end
      checks++; if (t1 - t0 != DDIV + 1) begin errors++; $display("FAIL areset_default_period got=%0d exp=%0d", t1 - t0, DDIV + 1); end
      $display("test_async_reset: period after re-init %0d", t1 - t0);
   endtask

   task automatic test_div0();
      int prev;
      apply_reset();
      run = 1'b0;
      for (int i = 0; i < 4; i++) cyc();
      div_value = 16'd0; div_load = 1'b1;
      cyc();
      div_load = 1'b0;
      for (int i = 6; i <= SC; i++) cyc();
      run = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         checks++; if (tick !== m_tick) begin errors++; $display("FAIL div0_start_tick cyc=%0d got=%b exp=%b", i, tick, m_tick); end
      end
      prev = int'(tick_phase);
      for (int i = 0; i < 6; i++) begin
         cyc();
         checks++; if (tick !== 1'b1) begin errors++; $display("FAIL div0_tick cyc=%0d got=%b exp=1", i, tick); end
         checks++; if (tick_phase !== 2'((prev + 1) % 4)) begin errors++; $display("FAIL div0_phase cyc=%0d got=%0d exp=%0d", i, tick_phase, (prev + 1) % 4); end
         prev = int'(tick_phase);
      end
      $display("test_div0: tick every cycle with div=0");
   endtask

   task automatic test_random();
      int nticks = 0;
      apply_reset();
      run = 1'b0;
      for (int i = 1; i <= 600; i++) begin
         if ($urandom_range(0, 11) == 0) run = ~run;
         div_load = ($urandom_range(0, 7) == 0);
         div_value = 16'($urandom_range(0, 5));
         cyc();
         checks++; if (tick !== m_tick) begin errors++; $display("FAIL rand_tick edge=%0d got=%b exp=%b", i, tick, m_tick); end
         checks++; if (tick_phase !== 2'(m_phase)) begin errors++; $display("FAIL rand_phase edge=%0d got=%0d exp=%0d", i, tick_phase, m_phase); end
         checks++; if (ready !== m_ready) begin errors++; $display("FAIL rand_ready edge=%0d got=%b exp=%b", i, ready, m_ready); end
         if (tick === 1'b1) nticks++;
      end
      div_load = 1'b0;
      $display("test_random: 600 edges, %0d ticks", nticks);
   endtask

   initial begin
      model_reset();
      test_reset();
      test_startup();
      test_basic();
      test_div_change();
      test_stop_restart();
      test_async_reset();
      test_div0();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
